// File: rtl/grn_write_arbiter.sv
// Merges NUM_CH kernel write streams into one tagged stream: 2 cycles request->out_req_write.
// A full channel FIFO withholds its ack; the output beat is held until out_ack_write.
module grn_write_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              ch_enable,
  input  logic [NUM_CH-1:0]              ch_req_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_transient,
  output logic [NUM_CH-1:0]              ch_ack_write,
  input  logic [NUM_CH-1:0]              ch_finish,
  output logic                           out_req_write,
  output logic [DATA_WIDTH-1:0]          out_transient,
  output logic [ID_W-1:0]                out_ch_id,
  input  logic                           out_ack_write,
  output logic                           all_finish,
  output logic [NUM_CH*CNT_WIDTH-1:0]    ch_wr_count,
  output logic                           protocol_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q [NUM_CH];
  logic [PTR_W:0]        rd_ptr_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0]     ack_q, ack_prev_q, req_prev_q, fin_q;
  logic                  out_req_q, perr_q;
  logic [DATA_WIDTH-1:0] out_dat_q;
  logic [ID_W-1:0]       out_id_q, rr_q, rr_d;
  logic [NUM_CH-1:0]     full, empty, push, pop;
  logic                  grant_vld, perr_set;
  logic [ID_W-1:0]       grant_id;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][PTR_W] != rd_ptr_q[i][PTR_W]) &&
                 (wr_ptr_q[i][PTR_W-1:0] == rd_ptr_q[i][PTR_W-1:0]);
      pop[i]   = out_req_q && out_ack_write && (out_id_q == ID_W'(i));
    end
    // full is taken before any same-cycle pop, so a full FIFO never pushes
    push = ch_enable & ch_req_write & ~full & ~ack_q;
  end

  // Lowest offset from the pointer wins, so scan offsets from the top down.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!empty[(int'(rr_q) + k) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'((int'(rr_q) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    rr_d = (int'(out_id_q) == NUM_CH - 1) ? '0 : out_id_q + 1'b1;
    // a request may fall in its ack cycle or the cycle after; any other fall abandons a beat
    perr_set = (out_ack_write && !out_req_q) ||
               |(req_prev_q & ~ch_req_write & ch_enable & ~ack_q & ~ack_prev_q);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][PTR_W-1:0]] <= ch_transient[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ack_q      <= '0;
      ack_prev_q <= '0;
      req_prev_q <= '0;
      fin_q      <= '0;
      out_req_q  <= 1'b0;
      out_dat_q  <= '0;
      out_id_q   <= '0;
      rr_q       <= '0;
      perr_q     <= 1'b0;
    end else begin
      ack_q      <= push;
      ack_prev_q <= ack_q;
      req_prev_q <= ch_req_write;
      fin_q      <= fin_q | ch_finish;
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
          cnt_q[i]    <= cnt_q[i] + 1'b1;
        end
      end
      if (out_req_q) begin
        if (out_ack_write) begin
          out_req_q <= 1'b0;
          rr_q      <= rr_d;
        end
      end else if (grant_vld) begin
        out_req_q <= 1'b1;
        out_dat_q <= mem_q[grant_id][rd_ptr_q[grant_id][PTR_W-1:0]];
        out_id_q  <= grant_id;
      end
      if (perr_set) perr_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign ch_wr_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign ch_ack_write  = ack_q;
  assign out_req_write = out_req_q;
  assign out_transient = out_dat_q;
  assign out_ch_id     = out_id_q;
  assign protocol_err  = perr_q;
  assign all_finish    = (&(~ch_enable | fin_q)) && (&empty) && !out_req_q;

endmodule

// File: tb/tb_grn_write_arbiter.sv
// Directed bench for grn_write_arbiter: kernel models on the input side, acking sink on the output.
module tb_grn_write_arbiter;
  localparam int NC = 4;
  localparam int DW = 512;
  localparam int CW = 32;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NC-1:0]    ch_enable = '0;
  logic [NC-1:0]    ch_req_write = '0;
  logic [NC*DW-1:0] ch_transient = '0;
  logic [NC-1:0]    ch_ack_write;
  logic [NC-1:0]    ch_finish = '0;
  logic             out_req_write;
  logic [DW-1:0]    out_transient;
  logic [IW-1:0]    out_ch_id;
  logic             out_ack_write = 1'b0;
  logic             all_finish;
  logic [NC*CW-1:0] ch_wr_count;
  logic             protocol_err;

  int errors = 0;
  int checks = 0;
  int k_n [NC];
  int k_idx [NC];
  int ack_cnt [NC];
  logic [NC-1:0] k_hold = '0;
  logic [NC-1:0] k_fin_en = '0;
  logic          ack_en = 1'b1;
  logic [7:0]    base = 8'h00;
  int            log_id [$];
  logic [DW-1:0] log_dat [$];

  grn_write_arbiter dut (
    .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable), .ch_req_write(ch_req_write),
    .ch_transient(ch_transient), .ch_ack_write(ch_ack_write), .ch_finish(ch_finish),
    .out_req_write(out_req_write), .out_transient(out_transient), .out_ch_id(out_ch_id),
    .out_ack_write(out_ack_write), .all_finish(all_finish), .ch_wr_count(ch_wr_count),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(int ch, int k);
    logic [7:0] b;
    b = base + 8'(ch * 16) + 8'(k);
    return {(DW/8){b}};
  endfunction

  function automatic logic [CW-1:0] cnt(int ch);
    return ch_wr_count[ch*CW +: CW];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      ch_req_write[i] = k_hold[i] || (k_idx[i] < k_n[i]);
      ch_transient[i*DW +: DW] = pat(i, k_idx[i]);
      ch_finish[i] = k_fin_en[i] && (k_idx[i] >= k_n[i]);
    end
    out_ack_write = ack_en && out_req_write;
    if (out_ack_write) begin
      log_id.push_back(int'(out_ch_id));
      log_dat.push_back(out_transient);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      if (ch_ack_write[i]) begin
        k_idx[i]++;
        ack_cnt[i]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < NC; i++) begin
      k_n[i] = 0;
      k_idx[i] = 0;
      ack_cnt[i] = 0;
    end
    k_hold = '0;
    k_fin_en = '0;
    ack_en = 1'b1;
    log_id.delete();
    log_dat.delete();
    drive();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int bound;
    logic fin_seen;
    int fin_log;
    logic fin_req;
    logic hit;

    for (int i = 0; i < NC; i++) begin
      k_n[i] = 0; k_idx[i] = 0; ack_cnt[i] = 0;
    end
    #1;
    chk("rst_out_req", out_req_write, 1'b0);
    chk("rst_ack", ch_ack_write, 4'b0000);
    chk("rst_data", out_transient, '0);
    chk("rst_id", out_ch_id, 2'd0);
    chk("rst_counts", ch_wr_count, '0);
    chk("rst_perr", protocol_err, 1'b0);
    chk("rst_all_finish_disabled", all_finish, 1'b1);
    ch_enable = 4'b1111;
    #1;
    chk("rst_all_finish_enabled", all_finish, 1'b0);

    // single beat on channel 1
    do_reset();
    base = 8'h95;
    step();
    k_n[1] = 1;
    drive();
    step();
    chk("sb_ack_t1", ch_ack_write, 4'b0010);
    chk("sb_req_t1", out_req_write, 1'b0);
    step();
    chk("sb_req_t2", out_req_write, 1'b1);
    chk("sb_id", out_ch_id, 2'd1);
    chk("sb_data", out_transient, {64{8'hA5}});
    chk("sb_ack_t2", ch_ack_write, 4'b0000);
    step();
    chk("sb_req_drop", out_req_write, 1'b0);
    chk("sb_count1", cnt(1), 32'd1);

    // round robin, 3 beats per channel
    do_reset();
    base = 8'h00;
    for (int i = 0; i < NC; i++) k_n[i] = 3;
    drive();
    bound = 0;
    while (log_id.size() < 12 && bound < 300) begin
      step();
      bound++;
    end
    step();
    chk("rr_beats", log_id.size(), 12);
    for (int j = 0; j < 12 && j < log_id.size(); j++) begin
      chk($sformatf("rr_id[%0d]", j), log_id[j], j % 4);
      chk($sformatf("rr_data[%0d]", j), log_dat[j], pat(j % 4, j / 4));
    end
    for (int i = 0; i < NC; i++) chk($sformatf("rr_count[%0d]", i), cnt(i), 32'd3);

    // backpressure: ch0 streams 6 beats into a depth-4 FIFO
    do_reset();
    ack_en = 1'b0;
    k_n[0] = 6;
    drive();
    repeat (30) step();
    chk("bp_acks", ack_cnt[0], 4);
    chk("bp_ack_now", ch_ack_write, 4'b0000);
    chk("bp_out_req", out_req_write, 1'b1);
    chk("bp_perr", protocol_err, 1'b0);
    ack_en = 1'b1;
    bound = 0;
    while (log_id.size() < 6 && bound < 300) begin
      step();
      bound++;
    end
    step();
    chk("bp_beats", log_id.size(), 6);
    for (int j = 0; j < 6 && j < log_id.size(); j++) begin
      chk($sformatf("bp_data[%0d]", j), log_dat[j], pat(0, j));
      chk($sformatf("bp_id[%0d]", j), log_id[j], 0);
    end
    chk("bp_count0", cnt(0), 32'd6);

    // finish: ch0..2 two beats each then finish; ch3 disabled but requesting
    do_reset();
    ch_enable = 4'b0111;
    for (int i = 0; i < 3; i++) k_n[i] = 2;
    k_fin_en = 4'b0111;
    k_hold[3] = 1'b1;
    drive();
    #1;
    chk("fin_initial", all_finish, 1'b0);
    fin_seen = 1'b0;
    fin_log = 0;
    fin_req = 1'b0;
    for (int c = 0; c < 300 && !fin_seen; c++) begin
      step();
      if (all_finish) begin
        fin_seen = 1'b1;
        fin_log = log_id.size();
        fin_req = out_req_write;
      end
    end
    chk("fin_seen", fin_seen, 1'b1);
    chk("fin_after_beats", fin_log, 6);
    chk("fin_out_req_low", fin_req, 1'b0);
    chk("fin_ch3_acks", ack_cnt[3], 0);
    chk("fin_counts", ch_wr_count, {32'd0, 32'd2, 32'd2, 32'd2});
    chk("fin_perr", protocol_err, 1'b0);

    // protocol error: ack with no request outstanding
    k_hold[3] = 1'b0;
    step();
    out_ack_write = 1'b1;
    step();
    chk("perr_set", protocol_err, 1'b1);
    chk("perr_out_req", out_req_write, 1'b0);
    repeat (3) step();
    chk("perr_sticky", protocol_err, 1'b1);
    chk("perr_counts", ch_wr_count, {32'd0, 32'd2, 32'd2, 32'd2});

    // asynchronous reset with beats buffered and output busy
    ch_enable = 4'b1111;
    ack_en = 1'b0;
    k_n[0] = k_idx[0] + 3;
    drive();
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      step();
      hit = out_req_write && ch_ack_write[0];
    end
    chk("ar_busy", hit, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_req", out_req_write, 1'b0);
    chk("ar_ack", ch_ack_write, 4'b0000);
    chk("ar_counts", ch_wr_count, '0);
    chk("ar_perr", protocol_err, 1'b0);
    do_reset();
    step();
    chk("ar_all_finish", all_finish, 1'b0);
    chk("ar_out_req_after", out_req_write, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grn_write_arbiter.md
Name: grn_write_arbiter

Overview:
- Parametrised successor to the single-kernel write path. Merges NUM_CH kernel write streams (req_write/ack_write/transient handshake) into one stream for the requestor.
- Per-channel FIFO buffering, round-robin grant, channel-id tagging, per-channel delivered-write counters, and an aggregated finish.
- Sits between NUM_CH top_grn-style kernel instances and grn_requestor.

Parameters:
- NUM_CH, 4, number of kernel channels (1..16).
- DATA_WIDTH, 512, width of one transient beat.
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2).
- CNT_WIDTH, 32, width of each delivered-write counter.
- ID_W, derived: max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- ch_enable  in  NUM_CH  per-channel enable.
- ch_req_write  in  NUM_CH  kernel write request, held until acked.
- ch_transient  in  NUM_CH*DATA_WIDTH  kernel data; channel i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- ch_ack_write  out  NUM_CH  one-cycle acceptance pulse to the kernel.
- ch_finish  in  NUM_CH  kernel done indication.
- out_req_write  out  1  merged write request.
- out_transient  out  DATA_WIDTH  merged data.
- out_ch_id  out  ID_W  source channel of the current beat.
- out_ack_write  in  1  one-cycle acceptance from the requestor.
- all_finish  out  1  all enabled channels are finished and fully drained.
- ch_wr_count  out  NUM_CH*CNT_WIDTH  writes delivered per channel.
- protocol_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_n=0, async):
  - FIFOs are emptied and pending data is discarded.
  - ch_ack_write=0, out_req_write=0, out_transient=0, out_ch_id=0.
  - Counters=0, finish latches=0, protocol_err=0, round-robin pointer=0.
  - all_finish is then driven by its combinational definition: 1 if ch_enable=0, else 0 until channels finish.
- Input capture, channel i, cycle t:
  - Condition: ch_enable[i]=1, ch_req_write[i]=1, FIFO i not full, and ch_ack_write[i]=0 in cycle t.
  - Then ch_transient slice i is pushed at the edge ending t, and ch_ack_write[i]=1 for exactly cycle t+1.
  - No capture on channel i during its ack cycle. Maximum rate per channel is 1 beat per 2 cycles.
- FIFO full: no capture and no ack. The kernel holds its request. Nothing is dropped.
- Disabled channel: the request is ignored and never acked. Existing FIFO contents still drain to the output.
- Output:
  - out_req_write, out_transient and out_ch_id are registered.
  - When out_req_write=0 and any FIFO is non-empty, grant the first non-empty channel at or after the RR pointer (wrapping). Load its head; out_req_write=1 from the next cycle.
  - Data and id are held stable while out_req_write=1.
  - On out_ack_write=1 with out_req_write=1:
    - pop the granted FIFO;
    - increment ch_wr_count[id] (wraps modulo 2^CNT_WIDTH);
    - set RR pointer = id+1 mod NUM_CH;
    - drop out_req_write the next cycle.
  - Next grant is evaluated the cycle after that. Output rate is at most 1 beat per 2 cycles.
- Empty -> first beat latency: capture edge, then grant edge. out_req_write rises 2 cycles after the kernel request is sampled.
- Simultaneous push and pop on the same FIFO: both take effect, and occupancy is unchanged.
- Full FIFO being popped in the same cycle: no push that cycle (full is evaluated before the pop).
- protocol_err is set (sticky until reset) on either:
  - out_ack_write=1 while out_req_write=0; the ack is otherwise ignored;
  - ch_req_write[i] falling while channel i is unacked, not in its ack cycle, and enabled.
- Finish:
  - ch_finish[i] is latched sticky.
  - all_finish = AND over i of (!ch_enable[i] | fin_latch[i]) AND all FIFOs empty AND out_req_write=0.
  - A finish asserted while beats are still buffered holds all_finish=0 until they drain.

Test Plan:
- Single beat: NUM_CH=4; ch1 req with data 0xA5 (replicated), out_ack the cycle after out_req rises. Expected:
  - ch_ack_write[1] pulse at t+1;
  - out_req at t+2 with out_ch_id=1;
  - ch_wr_count[1]=1.
- Round-robin: all 4 channels stream 3 beats each; out_ack whenever out_req is high. Expected:
  - out_ch_id order 0,1,2,3,0,1,2,3,0,1,2,3;
  - every count=3;
  - data order preserved per channel.
- Backpressure: out_ack held low, ch0 streams 6 beats, FIFO_DEPTH=4. Expected:
  - exactly 4 acks, then ch0 req held with no ack;
  - after releasing out_ack, all 6 beats delivered in order.
- Finish: ch0-ch2 enabled, ch3 disabled; each enabled channel delivers 2 beats then asserts finish. Expected:
  - all_finish=1 only after the 6th out_ack completes and out_req drops;
  - ch3 req never acked.
- Protocol error: out_ack pulse with out_req=0. Expected: protocol_err=1 and stays 1; counters unchanged.
- Reset mid-operation: reset_n low with 2 beats buffered and out_req high. Expected: out_req, ch_ack_write, counters and protocol_err go to 0 immediately, without waiting for a clock edge.
